// File: rtl/reg_file_pkg.sv
// Shared definitions for the arbitrated register file.
//   rst_val()      : reset value of each storage entry (8-bit, caller resizes)
//   CH_CTRL/CH_HOST: channel identifiers (system controller / debug host)
//   WR/RD          : access-type encodings on ChX_Wr
package reg_file_pkg;

  localparam logic CH_CTRL = 1'b0;
  localparam logic CH_HOST = 1'b1;

  localparam logic WR = 1'b1;
  localparam logic RD = 1'b0;

  // Entries 2 and 3 hold the power-on datapath configuration.
  function automatic logic [7:0] rst_val(input int idx);
    case (idx)
      2:       return 8'h21;
      3:       return 8'h20;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter.
//   clk, rst : clock, synchronous active-high reset
//   req[1:0] : request per channel
//   gnt[1:0] : one-hot grant, combinational from req and the pointer
// The pointer names the channel favoured on the next contested cycle and
// only moves when both channels request, so an uncontested stream does not
// disturb fairness.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic prio;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt       = 2'b00;
      gnt[prio] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      prio <= 1'b0;
    else if (req == 2'b11)
      prio <= ~prio;
  end

endmodule

// File: rtl/reg_file_arb.sv
// Register file shared by two requesters through a round-robin arbiter.
//   CLK, RST            : clock, synchronous active-high reset
//   ChN_Req/Wr/Addr/WrData : request, type (1=write), address, write data
//   ChN_Gnt             : request accepted this cycle (combinational)
//   RdData/RdData_VLD/RdChan/Err : registered read response, 1-cycle latency;
//                         Err also pulses (VLD=0) for out-of-range writes
//   CFG_REGS            : entries 0..NUM_CFG-1 straight from storage
// Build option REG_PARITY_EN adds a per-entry even-parity bit, the output
// RdPar_Err (pulsed with RdData_VLD) and the parity-corruption input Par_Inj.
module reg_file_arb
  import reg_file_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 16,
  parameter int ADDR    = 4,
  parameter int NUM_CFG = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     Ch0_Req,
  input  logic                     Ch0_Wr,
  input  logic [ADDR-1:0]          Ch0_Addr,
  input  logic [WIDTH-1:0]         Ch0_WrData,
  output logic                     Ch0_Gnt,
  input  logic                     Ch1_Req,
  input  logic                     Ch1_Wr,
  input  logic [ADDR-1:0]          Ch1_Addr,
  input  logic [WIDTH-1:0]         Ch1_WrData,
  output logic                     Ch1_Gnt,
  output logic [WIDTH-1:0]         RdData,
  output logic                     RdData_VLD,
  output logic                     RdChan,
  output logic                     Err,
`ifdef REG_PARITY_EN
  input  logic                     Par_Inj,
  output logic                     RdPar_Err,
`endif
  output logic [NUM_CFG*WIDTH-1:0] CFG_REGS
);

  logic [WIDTH-1:0] mem [DEPTH];
`ifdef REG_PARITY_EN
  logic             par [DEPTH];
  logic             par_err_p1;
`endif

  logic [1:0]       req;
  logic [1:0]       gnt;
  logic             granted;
  logic             sel;
  logic             acc_wr;
  logic [ADDR-1:0]  acc_addr;
  logic [WIDTH-1:0] acc_data;
  logic             in_range;

  logic [WIDTH-1:0] rd_data_p1;
  logic             vld_p1;
  logic             chan_p1;
  logic             err_p1;

  // No grant may be issued while reset is held.
  assign req = {Ch1_Req & ~RST, Ch0_Req & ~RST};

  rr_arb2 u_arb (
    .clk (CLK),
    .rst (RST),
    .req (req),
    .gnt (gnt)
  );

  assign Ch0_Gnt = gnt[0];
  assign Ch1_Gnt = gnt[1];

  // Stage p0: select the granted channel's access
  assign granted  = |gnt;
  assign sel      = gnt[1];
  assign acc_wr   = sel ? Ch1_Wr     : Ch0_Wr;
  assign acc_addr = sel ? Ch1_Addr   : Ch0_Addr;
  assign acc_data = sel ? Ch1_WrData : Ch0_WrData;
  assign in_range = {1'b0, acc_addr} < (ADDR+1)'(DEPTH);

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i[ADDR-1:0]] <= WIDTH'(rst_val(i));
`ifdef REG_PARITY_EN
        par[i[ADDR-1:0]] <= ^(WIDTH'(rst_val(i)));
`endif
      end
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
      chan_p1    <= CH_CTRL;
      err_p1     <= 1'b0;
`ifdef REG_PARITY_EN
      par_err_p1 <= 1'b0;
`endif
    end else begin
      vld_p1 <= 1'b0;
      err_p1 <= 1'b0;
`ifdef REG_PARITY_EN
      par_err_p1 <= 1'b0;
`endif
      if (granted) begin
        if (acc_wr == WR) begin
          if (in_range) begin
            mem[acc_addr] <= acc_data;
`ifdef REG_PARITY_EN
            par[acc_addr] <= (^acc_data) ^ Par_Inj;
`endif
          end else begin
            err_p1 <= 1'b1;
          end
        end else begin
          vld_p1     <= 1'b1;
          chan_p1    <= sel;
          err_p1     <= ~in_range;
          rd_data_p1 <= in_range ? mem[acc_addr] : '0;
`ifdef REG_PARITY_EN
          par_err_p1 <= in_range & ((^mem[acc_addr]) ^ par[acc_addr]);
`endif
        end
      end
    end
  end

  // Stage p1: registered response
  assign RdData     = rd_data_p1;
  assign RdData_VLD = vld_p1;
  assign RdChan     = chan_p1;
  assign Err        = err_p1;
`ifdef REG_PARITY_EN
  assign RdPar_Err  = par_err_p1;
`endif

  for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg
    assign CFG_REGS[g*WIDTH +: WIDTH] = mem[g];
  end

endmodule

// File: doc/reg_file_arb.md
Name: reg_file_arb

Overview:
Parametrised successor register file that serves two independent requesters through an internal round-robin arbiter.
- Requester 0 is the system controller; requester 1 is the debug/host path.
- One access, read or write, is granted per cycle.
- Reads return registered data with a valid pulse and a channel tag.
- Out-of-range addresses flag an error.
- The low configuration registers are exported as a flat bus to the datapath (ALU/UART/clock-divider config).

Parameters:
WIDTH, 8, data width of each entry
DEPTH, 16, number of implemented entries (1..2**ADDR)
ADDR, 4, address width
NUM_CFG, 4, number of entries exported on CFG_REGS (NUM_CFG <= DEPTH)

Ports:
CLK  in  1  clock; single clock domain
RST  in  1  reset, synchronous, active-high
Ch0_Req  in  1  channel 0 access request; held until Ch0_Gnt
Ch0_Wr  in  1  channel 0 type: 1 = write, 0 = read
Ch0_Addr  in  ADDR  channel 0 address
Ch0_WrData  in  WIDTH  channel 0 write data
Ch0_Gnt  out  1  channel 0 request accepted this cycle (combinational)
Ch1_Req, Ch1_Wr, Ch1_Addr, Ch1_WrData, Ch1_Gnt  same widths and meaning for channel 1
RdData  out  WIDTH  read data (registered)
RdData_VLD  out  1  one-cycle pulse; RdData/RdChan/Err are valid
RdChan  out  1  channel that issued the returned read
Err  out  1  one-cycle pulse: granted access had Addr >= DEPTH
CFG_REGS  out  NUM_CFG*WIDTH  entries 0..NUM_CFG-1, entry 0 in the LSBs; driven from storage flops, no extra latency

Behaviour:
Reset (synchronous, active-high):
- Takes effect at the first CLK edge with RST=1.
- Entry 2 = 8'h21 and entry 3 = 8'h20, zero-extended/truncated to WIDTH; all other entries = 0.
- RdData=0, RdData_VLD=0, RdChan=0, Err=0, round-robin pointer set so channel 0 wins the first contention.
- While RST=1, both Gnt outputs = 0 and no access commits.
- A read granted in the cycle before RST rises produces no VLD pulse, because reset wins at that edge.

Arbitration:
- Only one Req high: that channel is granted in the same cycle.
- Both Req high: the channel that did not win the last contested cycle is granted.
- The pointer updates only on contested cycles.
- A requester must hold Req/Wr/Addr/WrData stable until it sees Gnt. The loser waits; no starvation beyond 1 cycle.

Write:
- Granted with Addr < DEPTH: entry written at the same CLK edge.
- Granted with Addr >= DEPTH: write dropped, Err pulses the next cycle with RdData_VLD=0.

Read:
- Granted in cycle N: RdData, RdChan and RdData_VLD=1 are presented in cycle N+1; fixed latency 1.
- Addr >= DEPTH: RdData=0, Err=1, VLD=1.
- RdData holds its last value when VLD=0.

Ordering:
- A write granted in cycle N followed by a read of the same entry granted in N+1 returns the new data; no hazard because there is one access per cycle.
- Back-to-back reads give VLD high on consecutive cycles.

CFG_REGS reflects a write on the cycle after the write edge.

Optional Feature:
REG_PARITY_EN
- Defined:
  - Each entry stores an extra even-parity bit, computed on write and on reset values.
  - On read, the parity is recomputed; a mismatch drives an extra output RdPar_Err, pulsed with RdData_VLD.
  - Data is still returned unchanged.
  - A test-only input Par_Inj (1 bit) inverts the stored parity bit on the next granted write.
- Undefined: no parity storage, and neither the RdPar_Err nor the Par_Inj port exists.

Decomposition:
- Package reg_file_pkg:
  - Reset-value function/table indexed by entry (2 -> 8'h21, 3 -> 8'h20, else 0).
  - Channel ID localparams CH_CTRL=0, CH_HOST=1.
  - Access-type localparams WR=1, RD=0.
- Sub-module rr_arb2: two-request round-robin arbiter with a registered pointer and combinational grants; reused elsewhere.

Test Plan:
1. Reset -> read addresses 2 and 3 via ch0 -> RdData 8'h21 then 8'h20, each with VLD one cycle after Gnt and RdChan=0; CFG_REGS = 32'h2021_0000.
2. Ch0 writes 8'hA5 to addr 5 (cycle N), ch0 reads addr 5 (cycle N+1) -> RdData=8'hA5 at N+2, Err=0.
3. Both channels request reads (addr 1 and 4) for 4 cycles, each re-requesting after its Gnt -> grants alternate 0,1,0,1; RdChan alternates, each read 1 cycle after its grant.
4. DEPTH=12: ch1 writes addr 13 -> Err pulse, no entry changes; ch1 reads addr 13 -> RdData=0, VLD=1, Err=1, RdChan=1.
5. Ch0 read granted, RST asserted on the next edge -> no VLD pulse, all entries back to reset values, Gnt=0 while RST=1.
6. With REG_PARITY_EN: write 8'h3C with Par_Inj=1 to addr 7, then read addr 7 -> RdData=8'h3C, RdPar_Err=1; a read of addr 6 gives RdPar_Err=0.
